// File: rtl/veda_op_sequencer.sv
// veda_op_sequencer: command-driven controller that walks the two-address
// register file through read / compute / writeback sequences over a single
// shared rf_* interface. One command is in flight at a time; cmd_ready is
// only high while idle.
module veda_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rf_write_enable,
  output logic              rf_mode,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  output logic [DATA_W-1:0] rf_datain,
  input  logic [DATA_W-1:0] rf_dataout,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RDA  = 3'd1;
  localparam logic [2:0] S_RDB  = 3'd2;
  localparam logic [2:0] S_CAPA = 3'd3;
  localparam logic [2:0] S_CAPB = 3'd4;
  localparam logic [2:0] S_WB   = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_RD  = 3'd7;

  logic [2:0]        state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] alu_out;

  // The second operand is consumed straight off the read port in CAPB,
  // the one cycle in which it is valid.
  assign op_b = rf_dataout;

  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign rf_addr_b = rf_addr_a;

  // ALU: all arithmetic wraps modulo 2^DATA_W; shifts use the low 5 bits of op_b.
  always_comb begin
    alu_out = '0;
    case (op_q)
      OP_ADD:  alu_out = op_a + op_b;
      OP_SUB:  alu_out = op_a - op_b;
      OP_AND:  alu_out = op_a & op_b;
      OP_OR:   alu_out = op_a | op_b;
      OP_XOR:  alu_out = op_a ^ op_b;
      OP_SLL:  alu_out = op_a << op_b[4:0];
      default: alu_out = '0;
    endcase
  end

  // Sequencer: latch the command on accept, walk the read/compute/write
  // states, and update the visible result only as the command completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      op_a    <= '0;
      wb_data <= '0;
      result  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            rs1_q <= cmd_rs1;
            rs2_q <= cmd_rs2;
            rd_q  <= cmd_rd;
            if (cmd_op == OP_LDI) begin
              wb_data <= cmd_imm;
              state   <= S_WB;
            end else begin
              state <= S_RDA;
            end
          end
        end
        S_RDA: begin
          state <= (op_q == OP_RD) ? S_CAPA : S_RDB;
        end
        S_RDB: begin
          op_a  <= rf_dataout;
          state <= S_CAPB;
        end
        S_CAPA: begin
          op_a   <= rf_dataout;
          result <= rf_dataout;
          state  <= S_DONE;
        end
        S_CAPB: begin
          wb_data <= alu_out;
          state   <= S_WB;
        end
        S_WB: begin
          result <= wb_data;
          state  <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Register-file control decoded from the current state and latched
  // command fields only; idle and done park the port in read mode at 0.
  always_comb begin
    rf_write_enable = 1'b0;
    rf_mode         = 1'b1;
    rf_addr_a       = '0;
    rf_datain       = '0;
    case (state)
      S_RDA: rf_addr_a = rs1_q;
      S_RDB: rf_addr_a = rs2_q;
      S_WB: begin
        rf_mode         = 1'b0;
        rf_write_enable = 1'b1;
        rf_addr_a       = rd_q;
        rf_datain       = wb_data;
      end
      default: begin
        rf_write_enable = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/veda_op_sequencer.md
Name: veda_op_sequencer

Overview:
- Command-driven controller that sequences the 32x32 two-address register file (mod_veda) through a single shared read/write interface.
- Each accepted command performs one of:
  - read two source registers, compute an ALU result, write it back to a destination register;
  - load an immediate into a destination register;
  - read one register and return it, with no writeback.
- Sits between a command source (testbench or future decoder) and the register file, and owns every rf_* control line.

Parameters:
- DATA_W, 32: register and datapath width.
- ADDR_W, 5: register index width (32 entries).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  high only in IDLE; command accepted on the edge where cmd_valid & cmd_ready.
- cmd_op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 LDI, 7 RD.
- cmd_rs1  input  ADDR_W  source 1 index.
- cmd_rs2  input  ADDR_W  source 2 index.
- cmd_rd  input  ADDR_W  destination index.
- cmd_imm  input  DATA_W  immediate for LDI.
- rf_write_enable  output  1  to register file.
- rf_mode  output  1  0 = write (rf_datain -> reg[rf_addr_a]), 1 = read (reg[rf_addr_a] on rf_dataout).
- rf_addr_a  output  ADDR_W  register file address.
- rf_addr_b  output  ADDR_W  driven equal to rf_addr_a in all states.
- rf_datain  output  DATA_W  write data.
- rf_dataout  input  DATA_W  read data; valid in the cycle after the read address is presented.
- done  output  1  one-cycle pulse when a command completes.
- result  output  DATA_W  value written (or read for RD); held until the next done.

Behaviour:
- All command fields are latched on acceptance; later input changes are ignored.
- Reset (synchronous, rst high at a rising edge):
  - state = IDLE; cmd_ready = 1.
  - rf_write_enable = 0, rf_mode = 1, rf_addr_a/b = 0, rf_datain = 0.
  - done = 0, result = 0.
- FSM states:
  - IDLE: cmd_ready = 1, rf_write_enable = 0. On accept: LDI -> WB, else -> RDA.
  - RDA: rf_mode = 1, rf_addr_a = rs1. Next: RDB (RD op -> CAPA).
  - RDB: rf_mode = 1, rf_addr_a = rs2; capture op_a <= rf_dataout. Next: CAPB.
  - CAPA (RD only): capture op_a <= rf_dataout. Next: DONE.
  - CAPB: capture op_b <= rf_dataout; result register <= ALU(op_a, op_b). Next: WB.
  - WB: rf_mode = 0, rf_write_enable = 1, rf_addr_a = rd, rf_datain = result (imm for LDI). Next: DONE.
  - DONE: done = 1, rf_write_enable = 0, result valid. Next: IDLE.
- rf_write_enable is 1 only in WB; exactly one write per ALU/LDI command, none for RD.
- Latency from accept edge to done pulse:
  - ALU ops: 5 cycles (RDA, RDB, CAPB, WB, DONE).
  - LDI: 2 cycles.
  - RD: 3 cycles.
- Throughput: the next command can be accepted in the cycle after DONE.
- ALU arithmetic:
  - Modulo 2^DATA_W; no overflow flag.
  - SUB = op_a - op_b, two's complement wrap.
  - SLL shifts op_a left by op_b[4:0].
- rs1 == rs2 is legal; both reads return the same value.
- rd == rs1 or rd == rs2 is legal; the write occurs after both reads.
- Register 0 is an ordinary register (not hardwired).
- cmd_valid while busy: ignored, cmd_ready = 0, no queuing.
- rst mid-command: the next edge forces IDLE. If rst arrives during WB, that cycle's write may occur; no write is issued after rst. done is not pulsed for an aborted command.
- rf outputs are registered/decoded from state only; no combinational path from cmd_* to rf_*.

Test Plan:
- Reset then LDI rd=12 imm=55 -> WB has rf_mode=0, we=1, addr=12, datain=55; done 2 cycles after accept with result=55; cmd_ready back to 1 the cycle after done.
- LDI r10=56, LDI r12=55, ADD rs1=12 rs2=10 rd=13 -> done 5 cycles after accept, result=111; RD rs1=13 returns 111.
- SUB rs1=12 (55) rs2=10 (56) rd=2 -> result=32'hFFFFFFFF. SLL with op_a=1, op_b=33 -> result=2 (shift by 1).
- ADD rs1=10 rs2=10 rd=10 (56) -> result=112; RD r10 returns 112. Confirms the in-place write happens after the reads.
- Hold cmd_valid=1 with a second command throughout an ADD -> cmd_ready=0 for 5 cycles; second command accepted exactly one cycle after done; exactly one WB write per command.
- Assert rst during RDB of an ADD to rd=4 (r4 preloaded with 7) -> no done pulse, no write, rf_write_enable=0; RD r4 afterwards returns 7.
